// File: rtl/hazard_md_if.sv
// Bus between the datapath and hazard_md_unit: register indices, write/load
// flags and mul/div strobes in; forwarding selects, stall/flush and mul/div status out.
// HAZARD_STALL_CNT_EN adds the stall_cnt output.
interface hazard_md_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
);
    logic [REG_AW-1:0] rsD;
    logic [REG_AW-1:0] rtD;
    logic [REG_AW-1:0] rsE;
    logic [REG_AW-1:0] rtE;
    logic [REG_AW-1:0] writeregE;
    logic [REG_AW-1:0] writeregM;
    logic [REG_AW-1:0] writeregW;
    logic              regwriteE;
    logic              regwriteM;
    logic              regwriteW;
    logic              memtoregE;
    logic              memtoregM;
    logic              branchD;
    logic              hilo_useD;
    logic              mdstartE;
    logic              flushall;

    logic              forwardaD;
    logic              forwardbD;
    logic [1:0]        forwardaE;
    logic [1:0]        forwardbE;
    logic              stallF;
    logic              stallD;
    logic              flushD;
    logic              flushE;
    logic              md_busy;
    logic              md_done;
    logic              md_abort;
`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;
`endif

    // Reject degenerate widths at elaboration.
    if (REG_AW == 0 || CNT_W == 0) begin : g_bad_cfg
        $error("hazard_md_if: REG_AW and CNT_W must be non-zero");
    end

    // Datapath side.
    modport master (
`ifdef HAZARD_STALL_CNT_EN
        input  stall_cnt,
`endif
        output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
        output regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
        output branchD, hilo_useD, mdstartE, flushall,
        input  forwardaD, forwardbD, forwardaE, forwardbE,
        input  stallF, stallD, flushD, flushE, md_busy, md_done, md_abort
    );

    // Hazard unit side.
    modport slave (
`ifdef HAZARD_STALL_CNT_EN
        output stall_cnt,
`endif
        input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
        input  regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
        input  branchD, hilo_useD, mdstartE, flushall,
        output forwardaD, forwardbD, forwardaE, forwardbE,
        output stallF, stallD, flushD, flushE, md_busy, md_done, md_abort
    );
endinterface

// File: rtl/hazard_md_unit.sv
// Pipeline hazard controller: GPR forwarding, load-use/branch stalls, HI/LO
// interlock behind a mul/div latency countdown, and a pipeline-wide flush.
// Define HAZARD_STALL_CNT_EN to add a saturating stall-cycle counter (stall_cnt).
module hazard_md_unit #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned MD_LAT = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic         clk,
    input  logic         resetn,
    hazard_md_if.slave   bus
);
    localparam int unsigned MD_CW = $clog2(MD_LAT + 1);
    localparam logic [REG_AW-1:0] ZERO_REG = '0;

    // Reject configurations the countdown cannot represent.
    if (MD_LAT < 1 || CNT_W == 0 || REG_AW == 0) begin : g_bad_cfg
        $error("hazard_md_unit: MD_LAT must be >= 1, widths non-zero");
    end

    logic [MD_CW-1:0] cnt;
    logic             md_abort_q;
    logic             md_busy_w;
    logic             lwstall;
    logic             brstall;
    logic             mdstall;
    logic             stall;
    logic             stall_d;

    assign md_busy_w = (cnt != '0);

    // GPR forwarding selects; M stage wins over W, register 0 never forwards.
    always_comb begin
        bus.forwardaD = 1'b0;
        bus.forwardbD = 1'b0;
        bus.forwardaE = 2'b00;
        bus.forwardbE = 2'b00;

        bus.forwardaD = (bus.rsD != ZERO_REG) && (bus.rsD == bus.writeregM) && bus.regwriteM;
        bus.forwardbD = (bus.rtD != ZERO_REG) && (bus.rtD == bus.writeregM) && bus.regwriteM;

        if (bus.rsE != ZERO_REG) begin
            if ((bus.rsE == bus.writeregM) && bus.regwriteM) begin
                bus.forwardaE = 2'b10;
            end else if ((bus.rsE == bus.writeregW) && bus.regwriteW) begin
                bus.forwardaE = 2'b01;
            end
        end

        if (bus.rtE != ZERO_REG) begin
            if ((bus.rtE == bus.writeregM) && bus.regwriteM) begin
                bus.forwardbE = 2'b10;
            end else if ((bus.rtE == bus.writeregW) && bus.regwriteW) begin
                bus.forwardbE = 2'b01;
            end
        end
    end

    // Stall sources and pipeline-register controls; flushall overrides stalls.
    always_comb begin
        lwstall = bus.memtoregE &&
                  ((bus.rtE == bus.rsD) || (bus.rtE == bus.rtD));
        brstall = bus.branchD &&
                  ((bus.regwriteE && ((bus.writeregE == bus.rsD) || (bus.writeregE == bus.rtD))) ||
                   (bus.memtoregM && ((bus.writeregM == bus.rsD) || (bus.writeregM == bus.rtD))));
        mdstall = bus.hilo_useD && (md_busy_w || bus.mdstartE);
        stall   = lwstall || brstall || mdstall;
        stall_d = stall && !bus.flushall;

        bus.stallF = stall_d;
        bus.stallD = stall_d;
        bus.flushE = stall || bus.flushall;
        bus.flushD = bus.flushall;
    end

    // Mul/div latency countdown; a flush during busy cancels and flags an abort.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt        <= '0;
            md_abort_q <= 1'b0;
        end else begin
            md_abort_q <= 1'b0;
            if (bus.mdstartE && !bus.flushall) begin
                cnt <= MD_CW'(MD_LAT);
            end else if (bus.flushall && (cnt != '0)) begin
                cnt        <= '0;
                md_abort_q <= 1'b1;
            end else if (cnt != '0) begin
                cnt <= cnt - MD_CW'(1);
            end
        end
    end

    assign bus.md_busy  = md_busy_w;
    assign bus.md_done  = (cnt == MD_CW'(1));
    assign bus.md_abort = md_abort_q;

`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // Saturating count of cycles in which D is held.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stall_cnt_q <= '0;
        end else if (stall_d && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_md_unit.sv
// Self-checking bench for hazard_md_unit: table of combinational vectors plus
// directed sequences for mul/div countdown, abort, reset and the stall counter.
module tb_hazard_md_unit;
    logic clk = 1'b0;
    logic resetn;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    hazard_md_if #(.REG_AW(5), .CNT_W(2)) bus4  ();
    hazard_md_if #(.REG_AW(5), .CNT_W(2)) bus32 ();

    hazard_md_unit #(.REG_AW(5), .MD_LAT(4), .CNT_W(2)) u_dut4 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus4.slave)
    );

    hazard_md_unit #(.REG_AW(5), .MD_LAT(32), .CNT_W(2)) u_dut32 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus32.slave)
    );

    typedef struct {
        string      name;
        logic [4:0] rsD, rtD, rsE, rtE, weE, weM, weW;
        logic       rwE, rwM, rwW, mtrE, mtrM, brD, hiD, fl;
        logic [9:0] exp;   // {faD, fbD, faE[1:0], fbE[1:0], stallF, stallD, flushD, flushE}
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus4.rsD = '0;  bus4.rtD = '0;  bus4.rsE = '0;  bus4.rtE = '0;
        bus4.writeregE = '0; bus4.writeregM = '0; bus4.writeregW = '0;
        bus4.regwriteE = 1'b0; bus4.regwriteM = 1'b0; bus4.regwriteW = 1'b0;
        bus4.memtoregE = 1'b0; bus4.memtoregM = 1'b0; bus4.branchD = 1'b0;
        bus4.hilo_useD = 1'b0; bus4.mdstartE = 1'b0; bus4.flushall = 1'b0;
        bus32.rsD = '0; bus32.rtD = '0; bus32.rsE = '0; bus32.rtE = '0;
        bus32.writeregE = '0; bus32.writeregM = '0; bus32.writeregW = '0;
        bus32.regwriteE = 1'b0; bus32.regwriteM = 1'b0; bus32.regwriteW = 1'b0;
        bus32.memtoregE = 1'b0; bus32.memtoregM = 1'b0; bus32.branchD = 1'b0;
        bus32.hilo_useD = 1'b0; bus32.mdstartE = 1'b0; bus32.flushall = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        bus4.rsD = v.rsD; bus4.rtD = v.rtD; bus4.rsE = v.rsE; bus4.rtE = v.rtE;
        bus4.writeregE = v.weE; bus4.writeregM = v.weM; bus4.writeregW = v.weW;
        bus4.regwriteE = v.rwE; bus4.regwriteM = v.rwM; bus4.regwriteW = v.rwW;
        bus4.memtoregE = v.mtrE; bus4.memtoregM = v.mtrM; bus4.branchD = v.brD;
        bus4.hilo_useD = v.hiD; bus4.flushall = v.fl; bus4.mdstartE = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        next_cycle();
        resetn = 1'b1;
    endtask

    initial begin
        logic [9:0] got;

        //        name         rsD rtD rsE rtE wE wM wW rwE rwM rwW mtE mtM brD hiD fl  exp
        vecs[0]  = '{"idle",       0, 0, 0, 0, 0, 0, 0, 0,0,0, 0,0,0,0,0, 10'b00_00_00_0000};
        vecs[1]  = '{"fwd_m_prio", 0, 0, 8, 0, 0, 8, 8, 0,1,1, 0,0,0,0,0, 10'b00_10_00_0000};
        vecs[2]  = '{"fwd_rs0",    0, 0, 0, 0, 0, 8, 8, 0,1,1, 0,0,0,0,0, 10'b00_00_00_0000};
        vecs[3]  = '{"fwd_w",      0, 0, 8, 0, 0, 8, 8, 0,0,1, 0,0,0,0,0, 10'b00_01_00_0000};
        vecs[4]  = '{"fwd_b_w",    0, 0, 0, 9, 0, 0, 9, 0,0,1, 0,0,0,0,0, 10'b00_00_01_0000};
        vecs[5]  = '{"fwd_d",      7, 7, 0, 0, 0, 7, 0, 0,1,0, 0,0,0,0,0, 10'b11_00_00_0000};
        vecs[6]  = '{"fwd_d_r0",   0, 0, 0, 0, 0, 0, 0, 0,1,0, 0,0,0,0,0, 10'b00_00_00_0000};
        vecs[7]  = '{"lw_rs",      5, 0, 0, 5, 0, 0, 0, 0,0,0, 1,0,0,0,0, 10'b00_00_00_1101};
        vecs[8]  = '{"lw_drop",    5, 0, 0, 5, 0, 0, 0, 0,0,0, 0,0,0,0,0, 10'b00_00_00_0000};
        vecs[9]  = '{"lw_rt",      1, 6, 0, 6, 0, 0, 0, 0,0,0, 1,0,0,0,0, 10'b00_00_00_1101};
        vecs[10] = '{"lw_flush",   5, 0, 0, 5, 0, 0, 0, 0,0,0, 1,0,0,0,1, 10'b00_00_00_0011};
        vecs[11] = '{"br_e",       1, 3, 0, 0, 3, 0, 0, 1,0,0, 0,0,1,0,0, 10'b00_00_00_1101};
        vecs[12] = '{"br_m",       1, 3, 0, 0, 0, 3, 0, 0,0,0, 0,1,1,0,0, 10'b00_00_00_1101};
        vecs[13] = '{"br_none",    1, 3, 0, 0, 4, 0, 0, 1,0,0, 0,0,1,0,0, 10'b00_00_00_0000};
        vecs[14] = '{"hilo_idle",  0, 0, 0, 0, 0, 0, 0, 0,0,0, 0,0,0,1,0, 10'b00_00_00_0000};
        vecs[15] = '{"br_e_norw",  1, 3, 0, 0, 3, 0, 0, 0,0,0, 0,0,1,0,0, 10'b00_00_00_0000};

        resetn = 1'b0;
        clear_inputs();
        next_cycle();
        next_cycle();
        resetn = 1'b1;

        chk("rst_busy",  32'(bus4.md_busy),  32'd0);
        chk("rst_done",  32'(bus4.md_done),  32'd0);
        chk("rst_abort", 32'(bus4.md_abort), 32'd0);
`ifdef HAZARD_STALL_CNT_EN
        chk("rst_cnt",   32'(bus4.stall_cnt), 32'd0);
`endif

        // Combinational vector table.
        for (int i = 0; i < 16; i++) begin
            apply_vec(vecs[i]);
            #1;
            got = {bus4.forwardaD, bus4.forwardbD, bus4.forwardaE, bus4.forwardbE,
                   bus4.stallF, bus4.stallD, bus4.flushD, bus4.flushE};
            chk(vecs[i].name, 32'(got), 32'(vecs[i].exp));
            next_cycle();
        end

        // Mul/div MD_LAT=4 with mfhi waiting in D.
        clear_inputs();
        do_reset();
        bus4.mdstartE  = 1'b1;
        bus4.hilo_useD = 1'b1;
        #1;
        chk("md_t_stall", 32'(bus4.stallD), 32'd1);
        chk("md_t_busy",  32'(bus4.md_busy), 32'd0);
        next_cycle();
        bus4.mdstartE = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            #1;
            chk($sformatf("md_busy_t%0d",  k), 32'(bus4.md_busy), (k <= 4) ? 32'd1 : 32'd0);
            chk($sformatf("md_done_t%0d",  k), 32'(bus4.md_done), (k == 4) ? 32'd1 : 32'd0);
            chk($sformatf("md_stall_t%0d", k), 32'(bus4.stallD),  (k <= 4) ? 32'd1 : 32'd0);
            next_cycle();
        end
        bus4.hilo_useD = 1'b0;

        // Flush together with start: op discarded, no abort.
        bus4.mdstartE = 1'b1;
        bus4.flushall = 1'b1;
        next_cycle();
        bus4.mdstartE = 1'b0;
        bus4.flushall = 1'b0;
        #1;
        chk("flstart_busy",  32'(bus4.md_busy),  32'd0);
        chk("flstart_abort", 32'(bus4.md_abort), 32'd0);

        // Reset mid-operation: cancelled silently.
        bus4.mdstartE = 1'b1;
        next_cycle();
        bus4.mdstartE = 1'b0;
        chk("rstmid_busy_before", 32'(bus4.md_busy), 32'd1);
        do_reset();
        chk("rstmid_busy",  32'(bus4.md_busy),  32'd0);
        chk("rstmid_abort", 32'(bus4.md_abort), 32'd0);
        next_cycle();
        chk("rstmid_abort2", 32'(bus4.md_abort), 32'd0);

        // Abort with MD_LAT=32: start at t=0, flush at t=5.
        bus32.mdstartE = 1'b1;
        next_cycle();
        bus32.mdstartE = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("ab_busy_t%0d", k), 32'(bus32.md_busy), 32'd1);
            next_cycle();
        end
        bus32.flushall  = 1'b1;
        bus32.hilo_useD = 1'b1;
        #1;
        chk("ab_t5_flushD", 32'(bus32.flushD), 32'd1);
        chk("ab_t5_flushE", 32'(bus32.flushE), 32'd1);
        chk("ab_t5_stallD", 32'(bus32.stallD), 32'd0);
        chk("ab_t5_abort",  32'(bus32.md_abort), 32'd0);
        next_cycle();
        bus32.flushall  = 1'b0;
        bus32.hilo_useD = 1'b0;
        chk("ab_t6_busy",  32'(bus32.md_busy),  32'd0);
        chk("ab_t6_abort", 32'(bus32.md_abort), 32'd1);
        next_cycle();
        chk("ab_t7_abort", 32'(bus32.md_abort), 32'd0);

`ifdef HAZARD_STALL_CNT_EN
        // Saturating stall counter, CNT_W=2.
        clear_inputs();
        do_reset();
        bus4.memtoregE = 1'b1;
        bus4.rtE       = 5'd5;
        bus4.rsD       = 5'd5;
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            chk($sformatf("cnt_%0d", k), 32'(bus4.stall_cnt), (k < 3) ? 32'(k + 1) : 32'd3);
        end
        do_reset();
        chk("cnt_reset", 32'(bus4.stall_cnt), 32'd0);
`endif

        clear_inputs();
        next_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
